// File: rtl/data_mem_arbiter_if.sv
// Wishbone-style single-transfer bus (cyc/stb/we/ack) shared by the data-memory masters and slave.
// The master modport drives the request side; the slave modport returns ack and read data.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdat;
  logic              ack;
  logic [DATA_W-1:0] rdat;

  modport master (output cyc, stb, we, addr, wdat, input  ack, rdat);
  modport slave  (input  cyc, stb, we, addr, wdat, output ack, rdat);
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-master arbiter in front of the single-port data memory; owner keeps the slave for its cyc window.
// Define DMARB_ROUND_ROBIN_EN for round-robin ties; otherwise master 0 wins every tie.
module data_mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  data_mem_arbiter_if.slave  m0,
  data_mem_arbiter_if.slave  m1,
  data_mem_arbiter_if.master s,
  output logic [1:0]         gnt_o
);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;

  logic [1:0]        gnt, gnt_nxt, pick;
  logic [HW-1:0]     hold_cnt, hold_nxt;
  logic              own_cyc, own_stb, oth_cyc, forced;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdat_mux;
`ifdef DMARB_ROUND_ROBIN_EN
  logic              rr_last;  // set when master 0 took the most recent grant
`endif

  always_comb begin
    own_cyc = (gnt[0] & m0.cyc) | (gnt[1] & m1.cyc);
    own_stb = (gnt[0] & m0.stb) | (gnt[1] & m1.stb);
    oth_cyc = (gnt[0] & m1.cyc) | (gnt[1] & m0.cyc);

    pick = {m1.cyc & ~m0.cyc, m0.cyc};
`ifdef DMARB_ROUND_ROBIN_EN
    if (m0.cyc & m1.cyc & rr_last) pick = 2'b10;
`endif

    // Preemption only between transfers so a pending read ack is never stranded
    forced = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD)) && !own_stb && oth_cyc;

    if (!own_cyc)    gnt_nxt = pick;
    else if (forced) gnt_nxt = ~gnt;
    else             gnt_nxt = gnt;

    if (gnt_nxt != gnt)                 hold_nxt = '0;
    else if (!oth_cyc)                  hold_nxt = '0;
    else if (hold_cnt == HW'(MAX_HOLD)) hold_nxt = hold_cnt;
    else                                hold_nxt = hold_cnt + HW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gnt      <= 2'b00;
      hold_cnt <= '0;
`ifdef DMARB_ROUND_ROBIN_EN
      rr_last  <= 1'b1;
`endif
    end else begin
      gnt      <= gnt_nxt;
      hold_cnt <= hold_nxt;
`ifdef DMARB_ROUND_ROBIN_EN
      if (gnt_nxt != gnt && gnt_nxt != 2'b00) rr_last <= gnt_nxt[0];
`endif
    end
  end

  // Slave side is a pure mux of the registered owner; no owner means an idle bus
  always_comb begin
    addr_mux = '0;
    wdat_mux = '0;
    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    s.we     = 1'b0;
    if (gnt[0]) begin
      s.cyc = m0.cyc; s.stb = m0.stb; s.we = m0.we;
      addr_mux = m0.addr; wdat_mux = m0.wdat;
    end else if (gnt[1]) begin
      s.cyc = m1.cyc; s.stb = m1.stb; s.we = m1.we;
      addr_mux = m1.addr; wdat_mux = m1.wdat;
    end
    s.addr  = addr_mux;
    s.wdat  = wdat_mux;
    m0.ack  = gnt[0] & s.ack;
    m1.ack  = gnt[1] & s.ack;
    m0.rdat = s.rdat;
    m1.rdat = s.rdat;
  end

  assign gnt_o = gnt;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed and randomized bench for data_mem_arbiter with a small memory slave and an ownership model.
module tb_data_mem_arbiter;
  localparam int MAXH = 4;
`ifdef DMARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] gnt;
  int         n_cmp = 0, n_bad = 0, cyc_n = 0;

  always #5 clk = ~clk;

  data_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) m0_bus();
  data_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) m1_bus();
  data_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) s_bus();

  data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_HOLD(MAXH)) dut (
    .clk_i(clk), .rst_i(rst), .m0(m0_bus), .m1(m1_bus), .s(s_bus), .gnt_o(gnt)
  );

  // Memory slave: writes ack at once, reads ack a cycle later; cyc low drops a pending ack
  logic [7:0] mem [256];
  logic       rd_pend;
  logic [7:0] rd_q;
  assign s_bus.ack  = (s_bus.cyc & s_bus.stb & s_bus.we) | (rd_pend & s_bus.cyc);
  assign s_bus.rdat = rd_q;
  always_ff @(posedge clk) begin
    if (s_bus.cyc & s_bus.stb & s_bus.we) mem[s_bus.addr] <= s_bus.wdat;
    rd_q    <= mem[s_bus.addr];
    rd_pend <= rst ? 1'b0 : (s_bus.cyc & s_bus.stb & ~s_bus.we & ~rd_pend);
  end

  // Ownership model: -1 none, 0/1 master index
  int m_own = -1, m_hold = 0;
  bit m_rr = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc_n, got, exp);
    end
  endtask

  task automatic set_m0(input bit c, input bit st, input bit w, input logic [7:0] a, input logic [7:0] d);
    m0_bus.cyc = c; m0_bus.stb = st; m0_bus.we = w; m0_bus.addr = a; m0_bus.wdat = d;
  endtask

  task automatic set_m1(input bit c, input bit st, input bit w, input logic [7:0] a, input logic [7:0] d);
    m1_bus.cyc = c; m1_bus.stb = st; m1_bus.we = w; m1_bus.addr = a; m1_bus.wdat = d;
  endtask

  // Check this cycle's outputs against the model, advance the model, then cross the clock edge
  task automatic tick();
    logic [1:0] eg;
    logic       ec, es, ew, oc, wc, os;
    logic [7:0] ea, ed;
    int         nxt;
    #1;
    eg = (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00;
    ec = 1'b0; es = 1'b0; ew = 1'b0; ea = 8'h00; ed = 8'h00;
    if (m_own == 0) begin
      ec = m0_bus.cyc; es = m0_bus.stb; ew = m0_bus.we; ea = m0_bus.addr; ed = m0_bus.wdat;
    end else if (m_own == 1) begin
      ec = m1_bus.cyc; es = m1_bus.stb; ew = m1_bus.we; ea = m1_bus.addr; ed = m1_bus.wdat;
    end
    chk("gnt",     32'(gnt),          32'(eg));
    chk("s_cyc",   32'(s_bus.cyc),    32'(ec));
    chk("s_stb",   32'(s_bus.stb),    32'(es));
    chk("s_we",    32'(s_bus.we),     32'(ew));
    chk("s_addr",  32'(s_bus.addr),   32'(ea));
    chk("s_wdat",  32'(s_bus.wdat),   32'(ed));
    chk("m0_ack",  32'(m0_bus.ack),   32'((m_own == 0) && s_bus.ack));
    chk("m1_ack",  32'(m1_bus.ack),   32'((m_own == 1) && s_bus.ack));
    chk("m0_rdat", 32'(m0_bus.rdat),  32'(rd_q));
    chk("m1_rdat", 32'(m1_bus.rdat),  32'(rd_q));

    if (rst) begin
      m_own = -1; m_hold = 0; m_rr = 1'b1;
    end else begin
      oc = (m_own == 0) ? m0_bus.cyc : (m_own == 1) ? m1_bus.cyc : 1'b0;
      wc = (m_own == 0) ? m1_bus.cyc : (m_own == 1) ? m0_bus.cyc : 1'b0;
      os = (m_own == 0) ? m0_bus.stb : (m_own == 1) ? m1_bus.stb : 1'b0;
      nxt = m_own;
      if (!oc) begin
        if (m0_bus.cyc && m1_bus.cyc) nxt = (RR && m_rr) ? 1 : 0;
        else if (m0_bus.cyc)          nxt = 0;
        else if (m1_bus.cyc)          nxt = 1;
        else                          nxt = -1;
      end else if (m_hold == MAXH && !os && wc) begin
        nxt = 1 - m_own;
      end
      if (nxt != m_own)   m_hold = 0;
      else if (wc)        m_hold = (m_hold < MAXH) ? m_hold + 1 : MAXH;
      else                m_hold = 0;
      if (nxt != m_own && nxt >= 0) m_rr = (nxt == 0);
      m_own = nxt;
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_m0(0, 0, 0, 8'h00, 8'h00);
    set_m1(0, 0, 0, 8'h00, 8'h00);
    tick();
    tick();
    rst = 1'b0;
  endtask

  int sw;

  initial begin
    set_m0(0, 0, 0, 8'h00, 8'h00);
    set_m1(0, 0, 0, 8'h00, 8'h00);
    @(posedge clk);
    #1;

    // 1: reset held with both masters requesting, then release with only master 0
    rst = 1'b1;
    set_m0(1, 0, 0, 8'h00, 8'h00);
    set_m1(1, 0, 0, 8'h00, 8'h00);
    tick();
    tick();
    rst = 1'b0;
    set_m1(0, 0, 0, 8'h00, 8'h00);
    #1;
    chk("t1_rst_gnt",  32'(gnt),        32'(2'b00));
    chk("t1_rst_scyc", 32'(s_bus.cyc),  32'(0));
    chk("t1_rst_ack0", 32'(m0_bus.ack), 32'(0));
    chk("t1_rst_ack1", 32'(m1_bus.ack), 32'(0));
    tick();
    chk("t1_rel_gnt",  32'(gnt),        32'(2'b01));

    // 2: master 0 write then read back
    do_reset();
    set_m0(1, 1, 1, 8'h10, 8'h5A);
    tick();
    #1;
    chk("t2_wr_ack",   32'(m0_bus.ack), 32'(1));
    tick();
    set_m0(1, 1, 0, 8'h10, 8'h00);
    tick();
    #1;
    chk("t2_rd_ack",   32'(m0_bus.ack),  32'(1));
    chk("t2_rd_data",  32'(m0_bus.rdat), 32'(8'h5A));
    chk("t2_m1_ack",   32'(m1_bus.ack),  32'(0));
    set_m0(0, 0, 0, 8'h00, 8'h00);
    tick();

    // 3: simultaneous request, then winner releases
    do_reset();
    set_m0(1, 0, 0, 8'h00, 8'h00);
    set_m1(1, 0, 0, 8'h00, 8'h00);
    tick();
    chk("t3_tie_gnt", 32'(gnt), RR ? 32'(2'b10) : 32'(2'b01));
    if (RR) set_m1(0, 0, 0, 8'h00, 8'h00);
    else    set_m0(0, 0, 0, 8'h00, 8'h00);
    tick();
    chk("t3_next_gnt", 32'(gnt), RR ? 32'(2'b01) : 32'(2'b10));
    set_m0(0, 0, 0, 8'h00, 8'h00);
    set_m1(0, 0, 0, 8'h00, 8'h00);
    tick();

    // 4: master 0 hogs with alternating strobes while master 1 waits
    do_reset();
    set_m0(1, 0, 1, 8'h20, 8'h11);
    tick();
    sw = -1;
    for (int k = 1; k <= 12; k++) begin
      set_m0(1, k[0], 1, 8'h20, 8'h11);
      set_m1(1, 0, 0, 8'h30, 8'h00);
      if (sw < 0 && gnt == 2'b10) sw = k;
      tick();
    end
    chk("t4_switch_cycle", 32'(sw), 32'(7));

    // 5: handoff to a waiting writer, then master 0 reads its data
    do_reset();
    set_m0(1, 0, 0, 8'h00, 8'h00);
    tick();
    set_m1(1, 1, 1, 8'hFF, 8'hC3);
    tick();
    set_m0(0, 0, 0, 8'h00, 8'h00);
    tick();
    #1;
    chk("t5_s_addr", 32'(s_bus.addr), 32'(8'hFF));
    chk("t5_wr_ack", 32'(m1_bus.ack), 32'(1));
    tick();
    set_m1(0, 0, 0, 8'h00, 8'h00);
    set_m0(1, 1, 0, 8'hFF, 8'h00);
    tick();
    tick();
    #1;
    chk("t5_rd_ack",  32'(m0_bus.ack),  32'(1));
    chk("t5_rd_data", 32'(m0_bus.rdat), 32'(8'hC3));
    set_m0(0, 0, 0, 8'h00, 8'h00);
    tick();

    // 6: reset during a master 1 read, then the re-issued read completes
    do_reset();
    set_m1(1, 1, 0, 8'hFF, 8'h00);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_rst_gnt",  32'(gnt),        32'(2'b00));
    chk("t6_rst_ack1", 32'(m1_bus.ack), 32'(0));
    chk("t6_rst_scyc", 32'(s_bus.cyc),  32'(0));
    tick();
    tick();
    #1;
    chk("t6_rd_ack",  32'(m1_bus.ack),  32'(1));
    chk("t6_rd_data", 32'(m1_bus.rdat), 32'(8'hC3));
    set_m1(0, 0, 0, 8'h00, 8'h00);
    tick();

    // Randomized traffic against the ownership model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      set_m0($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      set_m1($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
